// File: rtl/ps2_synth_pkg.sv
// Shared scan-code constants, decoder state type and key-map lookup for the
// PS/2 keyboard synth front end.
package ps2_synth_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;

  localparam logic [7:0] SC_KEY_Z     = 8'h1A;
  localparam logic [7:0] SC_KEY_S     = 8'h1B;
  localparam logic [7:0] SC_KEY_X     = 8'h22;
  localparam logic [7:0] SC_KEY_D     = 8'h23;
  localparam logic [7:0] SC_KEY_C     = 8'h21;
  localparam logic [7:0] SC_KEY_V     = 8'h2A;
  localparam logic [7:0] SC_KEY_G     = 8'h34;
  localparam logic [7:0] SC_KEY_B     = 8'h32;
  localparam logic [7:0] SC_KEY_H     = 8'h33;
  localparam logic [7:0] SC_KEY_N     = 8'h31;
  localparam logic [7:0] SC_KEY_J     = 8'h3B;
  localparam logic [7:0] SC_KEY_M     = 8'h3A;
  localparam logic [7:0] SC_KEY_COMMA = 8'h41;

  localparam logic [7:0] SC_OCT_DOWN  = 8'h4E;
  localparam logic [7:0] SC_OCT_UP    = 8'h55;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic       valid;
    logic       is_octave;
    logic       up;
    logic [3:0] semitone;
  } key_info_t;

  // Maps a scan code to its musical meaning; semitone doubles as key index.
  function automatic key_info_t key_lookup(input logic [7:0] code);
    key_info_t info;
    info       = '0;
    info.valid = 1'b1;
    case (code)
      SC_KEY_Z:     info.semitone = 4'd0;
      SC_KEY_S:     info.semitone = 4'd1;
      SC_KEY_X:     info.semitone = 4'd2;
      SC_KEY_D:     info.semitone = 4'd3;
      SC_KEY_C:     info.semitone = 4'd4;
      SC_KEY_V:     info.semitone = 4'd5;
      SC_KEY_G:     info.semitone = 4'd6;
      SC_KEY_B:     info.semitone = 4'd7;
      SC_KEY_H:     info.semitone = 4'd8;
      SC_KEY_N:     info.semitone = 4'd9;
      SC_KEY_J:     info.semitone = 4'd10;
      SC_KEY_M:     info.semitone = 4'd11;
      SC_KEY_COMMA: info.semitone = 4'd12;
      SC_OCT_DOWN:  info.is_octave = 1'b1;
      SC_OCT_UP: begin
        info.is_octave = 1'b1;
        info.up        = 1'b1;
      end
      default:      info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Combinational scan-code to key-info lookup.
module ps2_key_map
  import ps2_synth_pkg::*;
(
  input  logic [7:0] code_i,
  output key_info_t  info_o
);

  assign info_o = key_lookup(code_i);

endmodule

// File: rtl/ps2_note_tracker.sv
// Polyphonic note tracker: decodes PS/2 make/break bytes, manages octave
// shift and allocates held keys to voice slots with one-cycle events.
module ps2_note_tracker
  import ps2_synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int BASE_NOTE  = 60,
  parameter int OCT_MAX    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   scan_code,
  input  logic                         scan_valid,
  input  logic                         panic,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         ev_on,
  output logic                         ev_off,
  output logic [2:0]                   ev_voice,
  output logic [NOTE_W-1:0]            ev_note,
  output logic                         overflow,
  output logic [2:0]                   octave
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic signed [2:0] OCT_HI = 3'(OCT_MAX);
  localparam logic signed [2:0] OCT_LO = 3'(-OCT_MAX);

  if (NUM_VOICES < 1 || NUM_VOICES > 8 || OCT_MAX < 0 || OCT_MAX > 3 ||
      BASE_NOTE - 12*OCT_MAX < 0 ||
      BASE_NOTE + 12*OCT_MAX + 12 >= (1 << NOTE_W)) begin : g_param_err
    $error("ps2_note_tracker: parameter set out of range");
  end

  dec_state_e                       state_q, state_d;
  logic [NUM_VOICES-1:0]            gate_q, gate_d;
  logic [3:0]                       key_q [NUM_VOICES];
  logic [3:0]                       key_d [NUM_VOICES];
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
  logic signed [2:0]                octave_q, octave_d;
  logic                             ev_on_q, ev_on_d;
  logic                             ev_off_q, ev_off_d;
  logic                             overflow_q, overflow_d;
  logic [2:0]                       ev_voice_q, ev_voice_d;
  logic [NOTE_W-1:0]                ev_note_q, ev_note_d;

  key_info_t          key_info;
  logic               is_make, is_break;
  logic               hit, free_found;
  logic [IDX_W-1:0]   hit_idx, free_idx;
  logic [NOTE_W-1:0]  new_note;

  ps2_key_map u_key_map (
    .code_i (scan_code),
    .info_o (key_info)
  );

  assign is_make  = scan_valid && !panic && (state_q == DEC_IDLE) &&
                    (scan_code != SC_BREAK) && (scan_code != SC_EXT);
  assign is_break = scan_valid && !panic && (state_q == DEC_BRK) &&
                    (scan_code != SC_BREAK);

  assign new_note = NOTE_W'(BASE_NOTE + 12 * int'(octave_q) + int'(key_info.semitone));

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= DEC_IDLE;
    else       state_q <= state_d;
  end

  // Decoder next state; advances only on valid bytes, panic forces IDLE.
  always_comb begin
    state_d = state_q;
    if (panic) begin
      state_d = DEC_IDLE;
    end else if (scan_valid) begin
      case (state_q)
        DEC_IDLE: begin
          if (scan_code == SC_BREAK)    state_d = DEC_BRK;
          else if (scan_code == SC_EXT) state_d = DEC_EXT;
        end
        DEC_BRK:     if (scan_code != SC_BREAK) state_d = DEC_IDLE;
        DEC_EXT:     state_d = (scan_code == SC_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
        DEC_EXT_BRK: state_d = DEC_IDLE;
        default:     state_d = DEC_IDLE;
      endcase
    end
  end

  // Slot search: held slot with matching key index, and lowest free slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (gate_q[i] && (key_q[i] == key_info.semitone) && !hit) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!gate_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Slot table, octave and event next-state.
  always_comb begin
    gate_d     = gate_q;
    key_d      = key_q;
    note_d     = note_q;
    octave_d   = octave_q;
    ev_on_d    = 1'b0;
    ev_off_d   = 1'b0;
    overflow_d = 1'b0;
    ev_voice_d = ev_voice_q;
    ev_note_d  = ev_note_q;
    if (panic) begin
      gate_d = '0;
    end else if (is_make && key_info.valid) begin
      if (key_info.is_octave) begin
        if (key_info.up) begin
          if (octave_q < OCT_HI) octave_d = octave_q + 3'sd1;
        end else if (octave_q > OCT_LO) begin
          octave_d = octave_q - 3'sd1;
        end
      end else if (!hit) begin
        if (free_found) begin
          gate_d[free_idx] = 1'b1;
          key_d[free_idx]  = key_info.semitone;
          note_d[free_idx] = new_note;
          ev_on_d          = 1'b1;
          ev_voice_d       = 3'(free_idx);
          ev_note_d        = new_note;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else if (is_break && key_info.valid && !key_info.is_octave && hit) begin
      // Released by key index so an octave change while held is harmless.
      gate_d[hit_idx] = 1'b0;
      ev_off_d        = 1'b1;
      ev_voice_d      = 3'(hit_idx);
      ev_note_d       = note_q[hit_idx];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q     <= '0;
      key_q      <= '{default: '0};
      note_q     <= '0;
      octave_q   <= '0;
      ev_on_q    <= 1'b0;
      ev_off_q   <= 1'b0;
      overflow_q <= 1'b0;
      ev_voice_q <= '0;
      ev_note_q  <= '0;
    end else begin
      gate_q     <= gate_d;
      key_q      <= key_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      ev_on_q    <= ev_on_d;
      ev_off_q   <= ev_off_d;
      overflow_q <= overflow_d;
      ev_voice_q <= ev_voice_d;
      ev_note_q  <= ev_note_d;
    end
  end

  assign voice_gate = gate_q;
  assign voice_note = note_q;
  assign ev_on      = ev_on_q;
  assign ev_off     = ev_off_q;
  assign ev_voice   = ev_voice_q;
  assign ev_note    = ev_note_q;
  assign overflow   = overflow_q;
  assign octave     = octave_q;

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Directed self-checking bench for ps2_note_tracker (default parameters).
module tb_ps2_note_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        panic;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic        ev_on, ev_off, overflow;
  logic [2:0]  ev_voice, octave;
  logic [6:0]  ev_note;

  int errors = 0;
  int checks = 0;
  int on_cnt = 0;
  int off_cnt = 0;
  int on_snap, off_snap;

  ps2_note_tracker #(
    .NUM_VOICES (4),
    .NOTE_W     (7),
    .BASE_NOTE  (60),
    .OCT_MAX    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .panic      (panic),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .ev_on      (ev_on),
    .ev_off     (ev_off),
    .ev_voice   (ev_voice),
    .ev_note    (ev_note),
    .overflow   (overflow),
    .octave     (octave)
  );

  always #5 clk = ~clk;

  // Event pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (ev_on)  on_cnt++;
    if (ev_off) off_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pulse_panic();
    @(negedge clk);
    panic = 1'b1;
    @(negedge clk);
    panic = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    panic      = 1'b0;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_gate", 32'(voice_gate), 0);
    chk("rst_note", 32'(voice_note), 0);
    chk("rst_on", 32'(ev_on), 0);
    chk("rst_off", 32'(ev_off), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_voice", 32'(ev_voice), 0);
    chk("rst_evnote", 32'(ev_note), 0);
    chk("rst_oct", 32'(octave), 0);

    // Single make/break
    send(8'h1A);
    chk("mk_on", 32'(ev_on), 1);
    chk("mk_voice", 32'(ev_voice), 0);
    chk("mk_note", 32'(ev_note), 60);
    chk("mk_gate", 32'(voice_gate), 4'b0001);
    send(8'hF0);
    chk("f0_on", 32'(ev_on), 0);
    chk("f0_gate", 32'(voice_gate), 4'b0001);
    send(8'h1A);
    chk("brk_off", 32'(ev_off), 1);
    chk("brk_on", 32'(ev_on), 0);
    chk("brk_note", 32'(ev_note), 60);
    chk("brk_voice", 32'(ev_voice), 0);
    chk("brk_gate", 32'(voice_gate), 0);

    // Fill all four slots, fifth overflows
    send(8'h1A);
    chk("fill0_on", 32'(ev_on), 1);
    chk("fill0_v", 32'(ev_voice), 0);
    chk("fill0_n", 32'(ev_note), 60);
    send(8'h22);
    chk("fill1_v", 32'(ev_voice), 1);
    chk("fill1_n", 32'(ev_note), 62);
    send(8'h21);
    chk("fill2_v", 32'(ev_voice), 2);
    chk("fill2_n", 32'(ev_note), 64);
    send(8'h2A);
    chk("fill3_on", 32'(ev_on), 1);
    chk("fill3_v", 32'(ev_voice), 3);
    chk("fill3_n", 32'(ev_note), 65);
    send(8'h32);
    chk("ovf", 32'(overflow), 1);
    chk("ovf_on", 32'(ev_on), 0);
    chk("ovf_gate", 32'(voice_gate), 4'b1111);
    chk("ovf_voice_held", 32'(ev_voice), 3);
    chk("ovf_note_held", 32'(ev_note), 65);
    chk("ovf_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));
    send(8'h31);
    chk("ovf_clear", 32'(overflow), 1);

    // Panic: gates clear, no release events, notes retained
    off_snap = off_cnt;
    pulse_panic();
    chk("pn_gate", 32'(voice_gate), 0);
    chk("pn_off", 32'(off_cnt), 32'(off_snap));
    chk("pn_notes", 32'(voice_note), 32'({7'd65, 7'd64, 7'd62, 7'd60}));

    // Typematic repeat and octave saturation
    on_snap = on_cnt;
    send(8'h1A);
    send(8'h1A);
    send(8'h1A);
    send(8'h1A);
    chk("rep_on_cnt", 32'(on_cnt), 32'(on_snap + 1));
    chk("rep_gate", 32'(voice_gate), 4'b0001);
    send(8'h55);
    send(8'h55);
    send(8'h55);
    chk("oct_sat_hi", 32'(octave), 3'b010);
    send(8'h22);
    chk("oct_mk_v", 32'(ev_voice), 1);
    chk("oct_mk_n", 32'(ev_note), 86);
    chk("oct_mk_gate", 32'(voice_gate), 4'b0011);
    pulse_panic();
    chk("pn_oct_kept", 32'(octave), 3'b010);
    repeat (5) send(8'h4E);
    chk("oct_sat_lo", 32'(octave), 3'b110);
    send(8'h55);
    send(8'h55);
    chk("oct_zero", 32'(octave), 0);

    // Octave change while held: release by key index
    send(8'h1A);
    chk("ochg_mk_n", 32'(ev_note), 60);
    send(8'h4E);
    chk("ochg_oct", 32'(octave), 3'b111);
    chk("ochg_held", 32'(voice_note[6:0]), 60);
    send(8'hF0);
    send(8'h1A);
    chk("ochg_off", 32'(ev_off), 1);
    chk("ochg_off_n", 32'(ev_note), 60);
    chk("ochg_off_v", 32'(ev_voice), 0);
    chk("ochg_gate", 32'(voice_gate), 0);
    send(8'h55);

    // Extended codes are discarded
    on_snap  = on_cnt;
    off_snap = off_cnt;
    send(8'hE0);
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    send(8'hE0);
    send(8'h1A);
    chk("ext_on_cnt", 32'(on_cnt), 32'(on_snap));
    chk("ext_gate", 32'(voice_gate), 0);
    send(8'h1A);
    chk("ext_next_on", 32'(ev_on), 1);
    chk("ext_next_n", 32'(ev_note), 60);
    send(8'hE0);
    send(8'hF0);
    send(8'h1A);
    chk("extbrk_off_cnt", 32'(off_cnt), 32'(off_snap));
    chk("extbrk_gate", 32'(voice_gate), 4'b0001);
    send(8'hF0);
    send(8'h1A);
    chk("ext_rel", 32'(voice_gate), 0);

    // Panic coinciding with a byte: byte discarded
    send(8'h1A);
    send(8'h22);
    chk("pc_gate_pre", 32'(voice_gate), 4'b0011);
    on_snap  = on_cnt;
    off_snap = off_cnt;
    @(negedge clk);
    scan_code  = 8'h22;
    scan_valid = 1'b1;
    panic      = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    panic      = 1'b0;
    chk("pc_gate", 32'(voice_gate), 0);
    chk("pc_on_cnt", 32'(on_cnt), 32'(on_snap));
    chk("pc_off_cnt", 32'(off_cnt), 32'(off_snap));
    send(8'h22);
    chk("pc_next_v", 32'(ev_voice), 0);
    chk("pc_next_n", 32'(ev_note), 62);

    // Back-to-back bytes: F0 22 (break) then 1A (make)
    off_snap = off_cnt;
    @(negedge clk);
    scan_code  = 8'hF0;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_code  = 8'h22;
    @(negedge clk);
    scan_code  = 8'h1A;
    @(negedge clk);
    scan_valid = 1'b0;
    chk("b2b_on", 32'(ev_on), 1);
    chk("b2b_n", 32'(ev_note), 60);
    chk("b2b_v", 32'(ev_voice), 0);
    chk("b2b_gate", 32'(voice_gate), 4'b0001);
    chk("b2b_off_cnt", 32'(off_cnt), 32'(off_snap + 1));

    // Reset mid-sequence discards the pending F0
    send(8'h55);
    send(8'hF0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_oct", 32'(octave), 0);
    chk("mrst_gate", 32'(voice_gate), 0);
    chk("mrst_notes", 32'(voice_note), 0);
    send(8'h1A);
    chk("mrst_on", 32'(ev_on), 1);
    chk("mrst_n", 32'(ev_note), 60);
    chk("mrst_gate2", 32'(voice_gate), 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
